// File: rtl/seven_segment_scanner_if.sv
// Bundles the scanner's load/value/blanking inputs and display-side outputs.
// The master side feeds values in; the slave side is the scanner itself.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    blank_lz;
    logic [3:0]              digit;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output load, value, blank_lz,
        input  digit, an, frame_done, pending
    );

    modport slave (
        input  load, value, blank_lz,
        output digit, an, frame_done, pending
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes a packed hex value onto one shared 7-segment decoder.
// Loads are double-buffered and committed only at frame wrap, so frames never tear.
module seven_segment_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    seven_segment_scanner_if.slave bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
    logic [NUM_DIGITS-1:0][3:0]   pend_q, pend_d;
    logic                         pend_v_q, pend_v_d;
    logic                         frame_done_q, frame_done_d;

    logic                         tick;
    logic                         last_pos;
    logic [NUM_DIGITS-1:0]        hi_zero;
    logic [NUM_DIGITS-1:0]        an_hot;
    logic                         blank;

    assign tick     = (cnt_q == CW'(PRESCALE - 1));
    assign last_pos = (idx_q == IW'(NUM_DIGITS - 1));

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        frame_done_d = 1'b0;
        if (tick) begin
            cnt_d = '0;
            if (last_pos) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
                if (pend_v_q) begin
                    disp_d   = pend_q;
                    pend_v_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        // A load on the commit edge wins pend_v: the new value waits one more frame.
        if (bus.load) begin
            pend_d   = bus.value;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            frame_done_q <= frame_done_d;
        end
    end

    // hi_zero[k]: nibbles k..NUM_DIGITS-1 of the display are all zero.
    always_comb begin
        logic acc;
        acc     = 1'b1;
        hi_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc        = acc && (disp_q[k] == 4'h0);
            hi_zero[k] = acc;
        end
    end

    assign an_hot = NUM_DIGITS'(1) << idx_q;
    assign blank  = bus.blank_lz && (idx_q != '0) && hi_zero[idx_q];

    assign bus.digit      = disp_q[idx_q];
    assign bus.an         = AN_ACTIVE_LOW ? ~(blank ? '0 : an_hot) : (blank ? '0 : an_hot);
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pend_v_q;
endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Upstream driver for the combinational seven_segment decoder. It takes a packed multi-digit hex value and time-multiplexes it onto one shared decoder. It outputs one 4-bit nibble (`digit`, wired to seven_segment.digit) plus a one-hot anode select, using a refresh prescaler. New values are double-buffered and committed only at frame boundaries, so a displayed frame never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions; legal range 1..8.
PRESCALE, 50000, clock cycles each digit stays selected; legal range >= 1.
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low, 0 = active-high.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  single-cycle strobe; captures `value` into the pending buffer.
value  input  4*NUM_DIGITS  packed hex value; nibble k drives position k; position 0 is least significant.
blank_lz  input  1  1 = suppress leading-zero digits (level, sampled every cycle).
digit  output  4  nibble for the currently selected position; feeds seven_segment.digit.
an  output  NUM_DIGITS  one-hot anode select for the current position, polarity per AN_ACTIVE_LOW.
frame_done  output  1  one-cycle pulse on the edge that wraps the scan from the last position to position 0.
pending  output  1  1 = a loaded value is waiting to be committed.

Behaviour:
- Internal state:
  - Prescaler `cnt` runs 0..PRESCALE-1; width is clog2(PRESCALE), minimum 1.
  - Scan index `idx` runs 0..NUM_DIGITS-1.
  - Display register `disp` and pending register `pend`, each 4*NUM_DIGITS bits.
  - Flag `pend_v`.
- Reset, asynchronous and immediate, including mid-frame:
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_v`=0, `frame_done`=0.
  - Outputs during reset: `digit`=0. `an` selects position 0, e.g. 4'b1110 for NUM_DIGITS=4, AN_ACTIVE_LOW=1. `pending`=0.
- Tick: `tick` = (`cnt`==PRESCALE-1).
  - On tick: `cnt`<=0 and `idx` advances by 1.
  - `idx` wraps from NUM_DIGITS-1 to 0.
  - Otherwise `cnt` increments.
  - PRESCALE=1 means tick every cycle.
  - Each position is held exactly PRESCALE cycles. One frame = NUM_DIGITS*PRESCALE cycles.
- Load:
  - On `load`=1: `pend`<=`value` and `pend_v`<=1.
  - Back-to-back loads overwrite `pend`; the last one wins.
- Commit:
  - Occurs on a tick with `idx`==NUM_DIGITS-1 and `pend_v`=1.
  - Same edge: `disp`<=`pend`, `idx`<=0, and `pend_v`<=0.
  - Position 0 of the new frame therefore shows the new value.
- Simultaneous load and commit on the same edge:
  - `disp` takes the old `pend`.
  - `pend` takes the new `value`.
  - `pend_v` stays 1, so the new value commits at the next frame boundary.
- `frame_done` is a registered pulse:
  - Set to 1 on the edge where `idx` wraps to 0, cleared on the next edge.
  - It asserts during the first cycle of position 0, regardless of whether a commit occurred.
- `pending` = `pend_v`.
- Outputs are combinational from registered state only, so they are glitch-free per position:
  - `digit` = `disp`[4*`idx` +: 4].
  - `an` = one-hot(`idx`), inverted when AN_ACTIVE_LOW=1.
- Leading-zero blanking:
  - Applies when `blank_lz`=1, `idx`>0, and nibbles `idx`..NUM_DIGITS-1 of `disp` are all zero.
  - Then `an` deasserts all positions (all 1s when active-low), and `digit` is unchanged.
  - Position 0 is never blanked, so the value 0 displays as "0".
- NUM_DIGITS=1: `idx` is constant 0 and every tick is a frame boundary.

Test Plan:
- Reset/idle (bench uses PRESCALE=4, NUM_DIGITS=4, AN_ACTIVE_LOW=1):
  - Stimulus: assert `rst` mid-count, release.
  - Required: `an`=1110, `digit`=0, `pending`=0 immediately. First `an`=1101 appears exactly 4 cycles after release.
- Scan order:
  - Stimulus: load 16'h1A2F, wait for a commit.
  - Required: sequence over one frame is (`an`,`digit`) = (1110,F), (1101,2), (1011,A), (0111,1), each held 4 cycles. `frame_done` pulses once per 16 cycles.
- Tear-free commit:
  - Stimulus: load 16'h1234 while `idx`=1.
  - Required: `pending`=1; digits keep showing the old value through position 3. Position 0 of the next frame shows 4 and `pending`=0 on the same edge.
- Load/commit collision:
  - Stimulus: pulse load with 16'hBEEF on the exact edge that commits 16'h1234.
  - Required: frame shows 1234 and `pending` stays 1. The following frame shows BEEF.
- Blanking:
  - Stimulus: `blank_lz`=1 with `disp`=16'h0050.
  - Required: positions 3 and 2 give `an`=1111; position 1 gives 1101 with `digit`=5; position 0 gives 1110 with `digit`=0.
  - Stimulus: `disp`=16'h0000.
  - Required: only position 0 is lit.
- Integration:
  - Stimulus: wire `digit` to the seven_segment decoder and load 16'h8888.
  - Required: decoder `seg` is constant at the "8" pattern whenever any anode is active.
